turn_lamp_decoder: RTL and testbench

//  Receive-side monitor for the six-lamp turn-signal interface (lc,lb,la,ra,rb,rc).

---
 rtl/turn_lamp_pkg.sv | 30 +++
 rtl/turn_lamp_classify.sv | 19 +
 rtl/turn_lamp_decoder.sv | 146 ++++++++++++++
 tb/tb_turn_lamp_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/turn_lamp_pkg.sv
// rtl/turn_lamp_pkg.sv - shared types and constants for the turn-lamp receive monitor
package turn_lamp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_A      = 3'd1,
        ST_AB     = 3'd2,
        ST_ABC    = 3'd3,
        ST_RESYNC = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        LC_OFF     = 3'd0,
        LC_A       = 3'd1,
        LC_AB      = 3'd2,
        LC_ABC     = 3'd3,
        LC_ILLEGAL = 3'd4
    } lamp_class_t;

    localparam logic [1:0] ERR_ILLEGAL = 2'd0;
    localparam logic [1:0] ERR_BOTH    = 2'd1;
    localparam logic [1:0] ERR_ORDER   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_A   = 3'b001;
    localparam logic [2:0] PAT_AB  = 3'b011;
    localparam logic [2:0] PAT_ABC = 3'b111;

endpackage

// File: rtl/turn_lamp_classify.sv
// rtl/turn_lamp_classify.sv - combinational {c,b,a} lamp pattern classifier
module turn_lamp_classify
    import turn_lamp_pkg::*;
(
    input  logic [2:0]  lamps,
    output lamp_class_t cls
);

    always_comb begin
        case (lamps)
            PAT_OFF: cls = LC_OFF;
            PAT_A:   cls = LC_A;
            PAT_AB:  cls = LC_AB;
            PAT_ABC: cls = LC_ABC;
            default: cls = LC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/turn_lamp_decoder.sv
// rtl/turn_lamp_decoder.sv - turn-signal lamp sequence checker with done counter and sticky error
module turn_lamp_decoder
    import turn_lamp_pkg::*;
#(
    parameter int HOLD_MAX = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lc,
    input  logic             lb,
    input  logic             la,
    input  logic             ra,
    input  logic             rb,
    input  logic             rc,
    input  logic             err_clr,
    output logic             active,
    output logic             side_left,
    output logic [1:0]       phase,
    output logic             seq_done,
    output logic [CNT_W-1:0] done_cnt,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int            HW       = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    lamp_class_t cls_l, cls_r, lat, oth, cur_cls, nxt_cls;
    state_t      state, state_nx, adv_state;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic        side_nx, viol, done;
    logic [1:0]  code_nx;

    turn_lamp_classify u_cls_l (.lamps({lc, lb, la}), .cls(cls_l));
    turn_lamp_classify u_cls_r (.lamps({rc, rb, ra}), .cls(cls_r));

    always_comb begin
        cur_cls   = LC_OFF;
        nxt_cls   = LC_ILLEGAL;
        adv_state = ST_IDLE;
        case (state)
            ST_A:    begin cur_cls = LC_A;   nxt_cls = LC_AB;  adv_state = ST_AB;  end
            ST_AB:   begin cur_cls = LC_AB;  nxt_cls = LC_ABC; adv_state = ST_ABC; end
            ST_ABC:  cur_cls = LC_ABC;
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        side_nx  = side_left;
        viol     = 1'b0;
        code_nx  = ERR_ORDER;
        done     = 1'b0;
        lat      = side_left ? cls_l : cls_r;
        oth      = side_left ? cls_r : cls_l;
        if (state == ST_RESYNC) begin
            hold_nx = '0;
            if (cls_l == LC_OFF && cls_r == LC_OFF)
                state_nx = ST_IDLE;
        end else if (cls_l != LC_OFF && cls_r != LC_OFF) begin
            viol    = 1'b1;
            code_nx = ERR_BOTH;
        end else if (cls_l == LC_ILLEGAL || cls_r == LC_ILLEGAL) begin
            viol    = 1'b1;
            code_nx = ERR_ILLEGAL;
        end else if (state == ST_IDLE) begin
            if (cls_l == LC_A) begin
                state_nx = ST_A;
                side_nx  = 1'b1;
                hold_nx  = HW'(1);
            end else if (cls_r == LC_A) begin
                state_nx = ST_A;
                side_nx  = 1'b0;
                hold_nx  = HW'(1);
            end else if (cls_l != LC_OFF || cls_r != LC_OFF) begin
                viol = 1'b1;
            end
        end else if (oth != LC_OFF) begin
            // lamps moved to the other side while the latched side went dark
            viol = 1'b1;
        end else if (lat == cur_cls) begin
            if (hold_cnt >= HOLD_LIM) begin
                viol    = 1'b1;
                code_nx = ERR_TIMEOUT;
            end else begin
                hold_nx = hold_cnt + 1'b1;
            end
        end else if (lat == nxt_cls) begin
            state_nx = adv_state;
            hold_nx  = HW'(1);
        end else if (state == ST_ABC && lat == LC_OFF) begin
            state_nx = ST_IDLE;
            hold_nx  = '0;
            done     = 1'b1;
        end else begin
            viol = 1'b1;
        end
        if (viol) begin
            state_nx = ST_RESYNC;
            hold_nx  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            side_left <= 1'b0;
            seq_done  <= 1'b0;
            done_cnt  <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state     <= state_nx;
            hold_cnt  <= hold_nx;
            side_left <= side_nx;
            seq_done  <= done;
            if (done && done_cnt != {CNT_W{1'b1}})
                done_cnt <= done_cnt + 1'b1;
            // first error wins, unless a clear arrives together with the new one
            if (viol) begin
                err <= 1'b1;
                if (!err || err_clr)
                    err_code <= code_nx;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end
        end
    end

    always_comb begin
        active = 1'b0;
        phase  = 2'd0;
        case (state)
            ST_A:    begin active = 1'b1; phase = 2'd1; end
            ST_AB:   begin active = 1'b1; phase = 2'd2; end
            ST_ABC:  begin active = 1'b1; phase = 2'd3; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_turn_lamp_decoder.sv
// tb/tb_turn_lamp_decoder.sv - randomized self-checking bench for turn_lamp_decoder
module tb_turn_lamp_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic lc = 1'b0, lb = 1'b0, la = 1'b0, ra = 1'b0, rb = 1'b0, rc = 1'b0;
    logic err_clr = 1'b0;

    logic       act0, side0, done0, err0, act1, side1, done1, err1;
    logic [1:0] ph0, ec0, ph1, ec1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    turn_lamp_decoder #(.HOLD_MAX(1), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .lc(lc), .lb(lb), .la(la), .ra(ra), .rb(rb), .rc(rc),
        .err_clr(err_clr), .active(act0), .side_left(side0), .phase(ph0), .seq_done(done0),
        .done_cnt(cnt0), .err(err0), .err_code(ec0)
    );

    turn_lamp_decoder #(.HOLD_MAX(2), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .lc(lc), .lb(lb), .la(la), .ra(ra), .rb(rb), .rc(rc),
        .err_clr(err_clr), .active(act1), .side_left(side1), .phase(ph1), .seq_done(done1),
        .done_cnt(cnt1), .err(err1), .err_code(ec1)
    );

    wire [15:0] obs0 = {act0, side0, ph0, done0, err0, ec0, cnt0};
    wire [15:0] obs1 = {act1, side1, ph1, done1, err1, ec1, 6'd0, cnt1};

    // Reference model: sequence progress as a lamp count on the active side.
    typedef struct {
        bit       resync;
        int       level;
        bit       left;
        int       run;
        bit       err;
        bit [1:0] code;
        bit       done;
        int       cnt;
    } mdl_t;

    mdl_t m[2];
    int   hold_max[2] = '{1, 2};
    int   cnt_max[2]  = '{255, 3};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [15:0] expect_word(input int i);
        return {m[i].level > 0, m[i].left, 2'(m[i].level), m[i].done, m[i].err, m[i].code,
                8'(m[i].cnt)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].resync = 0; m[i].level = 0; m[i].left = 0; m[i].run = 0;
            m[i].err = 0; m[i].code = 0; m[i].done = 0; m[i].cnt = 0;
        end
    endtask

    task automatic model_step(input int i, input bit [2:0] l, input bit [2:0] r, input bit clr);
        int nl, nr, mine, other, v;
        bit ok_l, ok_r;
        nl = $countones(l);
        nr = $countones(r);
        ok_l = int'(l) == (1 << nl) - 1;
        ok_r = int'(r) == (1 << nr) - 1;
        v = -1;
        m[i].done = 0;
        if (m[i].resync) begin
            if (nl == 0 && nr == 0) m[i].resync = 0;
        end else if (nl > 0 && nr > 0) begin
            v = 1;
        end else if (!ok_l || !ok_r) begin
            v = 0;
        end else if (m[i].level == 0) begin
            if (nl == 1) begin m[i].level = 1; m[i].left = 1; m[i].run = 1; end
            else if (nr == 1) begin m[i].level = 1; m[i].left = 0; m[i].run = 1; end
            else if (nl + nr > 0) v = 2;
        end else begin
            mine  = m[i].left ? nl : nr;
            other = m[i].left ? nr : nl;
            if (other > 0) v = 2;
            else if (mine == m[i].level) begin
                if (m[i].run + 1 > hold_max[i]) v = 3;
                else m[i].run++;
            end else if (mine == m[i].level + 1) begin
                m[i].level++; m[i].run = 1;
            end else if (m[i].level == 3 && mine == 0) begin
                m[i].level = 0; m[i].run = 0; m[i].done = 1;
                if (m[i].cnt < cnt_max[i]) m[i].cnt++;
            end else v = 2;
        end
        if (v >= 0) begin
            if (!m[i].err || clr) m[i].code = 2'(v);
            m[i].err = 1; m[i].resync = 1; m[i].level = 0; m[i].run = 0;
        end else if (clr) begin
            m[i].err = 0; m[i].code = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/i0"}, obs0, expect_word(0));
        check({tag, "/i1"}, obs1, expect_word(1));
    endtask

    task automatic step(input bit [2:0] l, input bit [2:0] r, input bit clr);
        {lc, lb, la} = l;
        {rc, rb, ra} = r;
        err_clr = clr;
        @(posedge clk);
        cyc++;
        model_step(0, l, r, clr);
        model_step(1, l, r, clr);
        @(negedge clk);
        check_all("step");
    endtask

    function automatic bit [2:0] pat(input int n);
        bit [2:0] p;
        p = 3'((1 << n) - 1);
        return p;
    endfunction

    task automatic run_seq(input bit left, input int h1, input int h2, input int h3, input int gap);
        int h[3];
        h = '{h1, h2, h3};
        for (int n = 1; n <= 3; n++)
            for (int k = 0; k < h[n-1]; k++)
                step(left ? pat(n) : 3'b000, left ? 3'b000 : pat(n), 1'b0);
        for (int k = 0; k < gap; k++) step(3'b000, 3'b000, 1'b0);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        {lc, lb, la, ra, rb, rc} = 6'd0;
        err_clr = 1'b0;
        reset = 1'b1;
        check_all("rst_release");
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b1;
        run_seq(1, 1, 1, 1, 1);
        run_seq(0, 1, 2, 1, 1);
        run_seq(0, 1, 1, 1, 1);
        step(3'b001, 3'b001, 0);
        step(3'b000, 3'b000, 1);
        step(3'b010, 3'b000, 0);
        step(3'b000, 3'b000, 1);
        step(3'b001, 3'b000, 0);
        step(3'b000, 3'b011, 0);
        step(3'b000, 3'b000, 0);
        step(3'b000, 3'b000, 1);
        for (int s = 0; s < 5; s++) run_seq(s[0], 1, 1, 1, 1);
        step(3'b111, 3'b000, 0);
        step(3'b001, 3'b000, 1);
        step(3'b000, 3'b000, 0);
        step(3'b001, 3'b000, 0);
        step(3'b011, 3'b000, 0);
        async_reset();
        run_seq(1, 1, 1, 1, 1);
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4:
                    run_seq(1'($urandom), $urandom_range(1, 2), $urandom_range(1, 3),
                            $urandom_range(1, 2), $urandom_range(0, 2));
                5: step(3'($urandom), 3'($urandom), 1'($urandom));
                6: step(3'b000, 3'b000, 1'b1);
                7: begin
                    step(3'b001, 3'b000, 0);
                    step(3'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0));
                    step(3'b000, 3'b000, 0);
                end
                8: step($urandom_range(0, 1) ? 3'b001 : 3'b000, 3'b000, 0);
                default: if ($urandom_range(0, 3) == 0) begin
                    step(3'b001, 3'b000, 0);
                    async_reset();
                end else begin
                    step(3'b000, 3'b000, 0);
                end
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
